// File: rtl/priority_encoder_pkg.sv
// -----------------------------------------------------------------------------
// priority_encoder_pkg
//
// Purpose : Shared sizing constants for the registered priority encoder.
//           PENC_WIDTH is the default request-vector width and PENC_OUT_W is
//           the matching encoded-index width.
//
// Ports   : none (package)
// -----------------------------------------------------------------------------
package priority_encoder_pkg;

    localparam int PENC_WIDTH = 256;
    localparam int PENC_OUT_W = $clog2(PENC_WIDTH);

endpackage : priority_encoder_pkg

// File: rtl/priority_encoder_if.sv
// -----------------------------------------------------------------------------
// priority_encoder_if
//
// Purpose : Bundles the request vector and the registered encoder result.
//
// Signals : in    [WIDTH-1:0] request vector, bit i set = index i requests
//           out   [OUT_W-1:0] registered index of highest set bit of in
//           valid             registered, 1 when in had any bit set
//
// Modports: master - request producer / result consumer (drives in)
//           slave  - the encoder (reads in, drives out and valid)
// -----------------------------------------------------------------------------
interface priority_encoder_if
    import priority_encoder_pkg::*;
#(
    parameter int WIDTH = PENC_WIDTH,
    parameter int OUT_W = $clog2(WIDTH)
);

    logic [WIDTH-1:0] in;
    logic [OUT_W-1:0] out;
    logic             valid;

    modport master (
        output in,
        input  out,
        input  valid
    );

    modport slave (
        input  in,
        output out,
        output valid
    );

endinterface : priority_encoder_if

// File: rtl/priority_encoder_node.sv
// -----------------------------------------------------------------------------
// priority_encoder_node
//
// Purpose : One merge node of the priority-encoder reduction tree. Combines
//           the (valid, index) pairs of an upper and a lower half into the
//           (valid, index) pair of the whole, upper half taking priority.
//
// Ports   : hi_i   [K:0]   upper-half pair, {valid, index[K-1:0]}
//           lo_i   [K:0]   lower-half pair, {valid, index[K-1:0]}
//           pair_o [K+1:0] merged pair, {valid, index[K:0]}
//
// With K = 0 the inputs are raw request bits (a valid with no index).
// -----------------------------------------------------------------------------
module priority_encoder_node
    import priority_encoder_pkg::*;
#(
    parameter int K = 0
) (
    input  logic [K:0]   hi_i,
    input  logic [K:0]   lo_i,
    output logic [K+1:0] pair_o
);

    logic hi_vld;
    logic lo_vld;

    assign hi_vld = hi_i[K];
    assign lo_vld = lo_i[K];

    generate
        if (K == 0) begin : g_leaf
            // Raw bits: the new index MSB is simply "upper bit set".
            assign pair_o = {hi_vld | lo_vld, hi_vld};
        end else begin : g_merge
            // Upper half wins whenever it has any request; its index gets
            // MSB=1, otherwise the lower index is passed with MSB=0.
            assign pair_o = {hi_vld | lo_vld,
                             hi_vld,
                             hi_vld ? hi_i[K-1:0] : lo_i[K-1:0]};
        end
    endgenerate

endmodule : priority_encoder_node

// File: rtl/priority_encoder.sv
// -----------------------------------------------------------------------------
// priority_encoder
//
// Purpose : Registered priority encoder. Reduces a WIDTH-bit request vector
//           to the index of its highest set bit plus a valid flag, through a
//           log2(WIDTH)-deep tree of merge nodes followed by one register
//           stage. Latency is one clock, throughput one result per clock.
//
// Ports   : clk    system clock, rising edge
//           rst_n  asynchronous active-low reset, clears out and valid
//           bus    priority_encoder_if.slave: in (request), out/valid (result)
//
// WIDTH must be a power of two and at least 2. An all-zero request gives
// out=0, valid=0; a request with only bit 0 set gives out=0, valid=1, so
// consumers must qualify out with valid.
// -----------------------------------------------------------------------------
module priority_encoder
    import priority_encoder_pkg::*;
#(
    parameter int WIDTH = PENC_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    priority_encoder_if.slave bus
);

    localparam int OUT_W = $clog2(WIDTH);

    // Level l holds WIDTH >> (l+1) pairs, each (l+2) bits wide:
    // {valid, index[l:0]}. Level 0 consumes raw request bits.
    generate
        for (genvar l = 0; l < OUT_W; l++) begin : g_lvl
            localparam int NODES  = WIDTH >> (l + 1);
            localparam int IN_W   = l + 1;
            localparam int PAIR_W = l + 2;

            logic [NODES*PAIR_W-1:0] pairs;

            for (genvar n = 0; n < NODES; n++) begin : g_node
                logic [IN_W-1:0] hi;
                logic [IN_W-1:0] lo;

                if (l == 0) begin : g_from_req
                    assign hi = bus.in[2*n+1];
                    assign lo = bus.in[2*n];
                end else begin : g_from_lvl
                    assign hi = g_lvl[l-1].pairs[(2*n+1)*IN_W +: IN_W];
                    assign lo = g_lvl[l-1].pairs[(2*n)*IN_W   +: IN_W];
                end

                priority_encoder_node #(
                    .K (l)
                ) u_node (
                    .hi_i   (hi),
                    .lo_i   (lo),
                    .pair_o (pairs[n*PAIR_W +: PAIR_W])
                );
            end
        end
    endgenerate

    // ---- tree root -> output register ----
    logic [OUT_W-1:0] out_d;
    logic [OUT_W-1:0] out_q;
    logic             valid_d;
    logic             valid_q;

    assign {valid_d, out_d} = g_lvl[OUT_W-1].pairs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.valid = valid_q;

endmodule : priority_encoder

// File: tb/tb_priority_encoder.sv
// -----------------------------------------------------------------------------
// tb_priority_encoder
//
// Self-checking bench for priority_encoder (WIDTH = 256). Directed table of
// priority vectors, hand-written reset / walking-one / back-to-back / async
// reset sequences, and random vectors checked against a reference that takes
// the maximum set index.
// -----------------------------------------------------------------------------
module tb_priority_encoder;

    localparam int W  = 256;
    localparam int OW = 8;

    logic clk;
    logic rst_n;

    priority_encoder_if #(.WIDTH(W)) bus ();

    priority_encoder #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk  = 0;
    int nfail = 0;

    typedef struct {
        string           name;
        logic [W-1:0]    vec;
        logic [OW-1:0]   exp_out;
        logic            exp_vld;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string nm, input logic [OW-1:0] eo, input logic ev);
        nchk++;
        if (bus.out !== eo || bus.valid !== ev) begin
            nfail++;
            $display("FAIL %s: got out=%0d valid=%0b, expected out=%0d valid=%0b",
                     nm, bus.out, bus.valid, eo, ev);
        end
    endtask

    // Reference: the result is the largest index whose bit is set.
    function automatic void ref_enc(input logic [W-1:0] v,
                                    output logic [OW-1:0] o,
                                    output logic vl);
        int best;
        best = -1;
        for (int i = 0; i < W; i++)
            if (v[i] && i > best) best = i;
        vl = (best >= 0);
        o  = (best >= 0) ? OW'(best) : '0;
    endfunction

    // Drive between edges, check one cycle later.
    task automatic apply_check(input string nm, input logic [W-1:0] v,
                               input logic [OW-1:0] eo, input logic ev);
        @(negedge clk);
        bus.in = v;
        @(posedge clk);
        #1;
        check(nm, eo, ev);
    endtask

    function automatic logic [W-1:0] bits(input int a, input int b, input int c);
        logic [W-1:0] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        return v;
    endfunction

    initial begin
        logic [W-1:0]  v;
        logic [OW-1:0] eo;
        logic          ev;
        int            mode;

        tbl[0] = '{"prio_255_0",    bits(255, 0, -1),   8'd255, 1'b1};
        tbl[1] = '{"prio_128_127",  bits(128, 127, -1), 8'd128, 1'b1};
        tbl[2] = '{"prio_7_3_1",    bits(7, 3, 1),      8'd7,   1'b1};
        tbl[3] = '{"prio_all_ones", {W{1'b1}},          8'd255, 1'b1};
        tbl[4] = '{"zero_input",    '0,                 8'd0,   1'b0};
        tbl[5] = '{"bit0_only",     bits(0, -1, -1),    8'd0,   1'b1};
        tbl[6] = '{"prio_64_63_2",  bits(64, 63, 2),    8'd64,  1'b1};
        tbl[7] = '{"bit1_only",     bits(1, -1, -1),    8'd1,   1'b1};

        // Reset held with all requests active: outputs stay cleared.
        rst_n  = 1'b0;
        bus.in = {W{1'b1}};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", 8'd0, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release_before_edge", 8'd0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_release_first_edge", 8'd255, 1'b1);

        // Directed priority table.
        for (int i = 0; i < 8; i++)
            apply_check(tbl[i].name, tbl[i].vec, tbl[i].exp_out, tbl[i].exp_vld);

        // Walking one from bit 255 down to bit 0.
        for (int i = W - 1; i >= 0; i--) begin
            v = '0;
            v[i] = 1'b1;
            apply_check("walking_one", v, OW'(i), 1'b1);
        end

        // Back-to-back results, and no combinational path from in to out.
        @(negedge clk);
        bus.in = bits(10, -1, -1);
        @(posedge clk);
        #1;
        check("stream_10", 8'd10, 1'b1);
        @(negedge clk);
        bus.in = bits(200, -1, -1);
        #1;
        check("stream_no_comb_path", 8'd10, 1'b1);
        @(posedge clk);
        #1;
        check("stream_200", 8'd200, 1'b1);
        @(negedge clk);
        bus.in = bits(50, -1, -1);
        @(posedge clk);
        #1;
        check("stream_50", 8'd50, 1'b1);

        // Random vectors of varied density.
        for (int n = 0; n < 300; n++) begin
            mode = int'($urandom_range(0, 3));
            v = '0;
            case (mode)
                0: for (int w = 0; w < W / 32; w++) v[w*32 +: 32] = $urandom;
                1: v[$urandom_range(0, W - 1)] = 1'b1;
                2: repeat ($urandom_range(1, 4)) v[$urandom_range(0, W - 1)] = 1'b1;
                default: begin
                    // Sparse low-half only, leaves upper half empty.
                    for (int w = 0; w < W / 64; w++)
                        v[w*32 +: 32] = $urandom & $urandom & $urandom;
                end
            endcase
            ref_enc(v, eo, ev);
            apply_check("random", v, eo, ev);
        end

        // Asynchronous reset between edges while valid is high.
        apply_check("pre_async_reset", {W{1'b1}}, 8'd255, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", 8'd0, 1'b0);
        @(posedge clk);
        #1;
        check("async_reset_held", 8'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_check("after_async_reset", bits(5, -1, -1), 8'd5, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule : tb_priority_encoder
